// File: rtl/ii_pkg.sv
// Shared defaults and FSM state encoding for the integral-image generator.
// Exports: PIX_W_DEF, SUM_W_DEF, DIM_W_DEF, MAX_WIDTH_DEF, state_t {IDLE, RUN, DRAIN, DONE}.
// Pure declarations, no logic.
package ii_pkg;

  localparam int PIX_W_DEF     = 8;
  localparam int SUM_W_DEF     = 32;
  localparam int DIM_W_DEF     = 16;
  localparam int MAX_WIDTH_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ii_line_buffer.sv
// One-row line buffer holding the previous row's integral values, indexed by column.
// Ports: clk; wr_en/wr_addr/wr_data (synchronous write); rd_addr/rd_data (combinational read).
// Latency: read is combinational; a same-address write in the same cycle is seen the next cycle.
module ii_line_buffer
  import ii_pkg::*;
#(
  parameter int DEPTH  = MAX_WIDTH_DEF,
  parameter int DATA_W = SUM_W_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: the combinational read returns the old row's value
  // even when the same column is being overwritten this cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/integral_image_gen.sv
// Streaming summed-area table generator: raster-order 8-bit pixels in, II(x,y) out.
// Ports: clk/reset, cfg_width/cfg_height/start -> busy/done, s_* pixel stream in, m_* integral stream out.
// Latency 1 cycle accept->m_valid; single output register, s_ready drops while m_valid && !m_ready.
module integral_image_gen
  import ii_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int PIX_W     = PIX_W_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int DIM_W     = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SUM_W-1:0] m_sum,
  output logic             m_eol,
  output logic             m_eof
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  state_t           state, state_nxt;
  logic [DIM_W-1:0] width_q, height_q;
  logic [DIM_W-1:0] x, y;
  logic [SUM_W-1:0] row_sum, rs, ii_val, lb_rd;
  logic             accept, beat_taken, last_col, last_row, dims_bad;

  assign s_ready    = (state == RUN) && (!m_valid || m_ready);
  assign accept     = s_valid && s_ready;
  assign beat_taken = m_valid && m_ready;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  assign last_col = (x == width_q - DIM_W'(1));
  assign last_row = (y == height_q - DIM_W'(1));
  assign dims_bad = (cfg_width == '0) || (cfg_height == '0) ||
                    (cfg_width > DIM_W'(MAX_WIDTH));

  // Running sum of the current row up to and including column x, plus the
  // integral value directly above (row 0 has nothing above it).
  assign rs     = ((x == '0) ? '0 : row_sum) + SUM_W'(s_pixel);
  assign ii_val = rs + ((y == '0) ? '0 : lb_rd);

  ii_line_buffer #(
    .DEPTH  (MAX_WIDTH),
    .DATA_W (SUM_W),
    .AW     (AW)
  ) u_lb (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (x[AW-1:0]),
    .wr_data (ii_val),
    .rd_addr (x[AW-1:0]),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dims_bad ? DONE : RUN;
      RUN:     if (accept && last_col && last_row) state_nxt = DRAIN;
      DRAIN:   if (beat_taken && m_eof) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q  <= '0;
      height_q <= '0;
      x        <= '0;
      y        <= '0;
      row_sum  <= '0;
      m_valid  <= 1'b0;
      m_sum    <= '0;
      m_eol    <= 1'b0;
      m_eof    <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        x        <= '0;
        y        <= '0;
        row_sum  <= '0;
      end

      if (accept) begin
        row_sum <= rs;
        m_sum   <= ii_val;
        m_valid <= 1'b1;
        m_eol   <= last_col;
        m_eof   <= last_col && last_row;
        if (last_col) begin
          x <= '0;
          y <= y + DIM_W'(1);
        end else begin
          x <= x + DIM_W'(1);
        end
      end else if (beat_taken) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
